ovo_vote_collector: RTL and testbench
=====================================

Name: ovo_vote_collector

Overview:
- Consumer end of the binary SVM result interface.
- Drives a free-running sequential binary SVM through all one-vs-one class pairs by selecting its weight/bias set.
- Captures each binary decision on its ready strobe and accumulates per-class votes.
- Produces the final multiclass label by a sequential argmax, with a one-cycle valid pulse.

Parameters:
- N_CLASSES, 10, number of classes; N_PAIRS = N_CLASSES*(N_CLASSES-1)/2 is derived.
- N_FEATURES, 16, features per binary SVM; one SVM round is N_FEATURES+1 cycles.
- VOTE_WIDTH, $clog2(N_CLASSES), width of each vote counter (max vote is N_CLASSES-1).
- LABEL_WIDTH, $clog2(N_CLASSES), width of the output label.
- PAIR_WIDTH, $clog2(N_PAIRS), width of the pair selector.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- start  in  1  single-cycle request to classify the currently presented feature vector
- svm_ready  in  1  binary SVM round-complete strobe
- svm_class  in  1  binary SVM decision bit (sign of final sum), valid when svm_ready=1
- pair_sel  out  PAIR_WIDTH  index of the active pair; drives the weight/bias mux
- busy  out  1  high from the cycle after an accepted start until the cycle label_valid pulses
- label  out  LABEL_WIDTH  winning class, held until the next label_valid
- label_valid  out  1  one-cycle pulse when label updates
- timeout_err  out  1  sticky error flag; cleared by the next accepted start

Behaviour:
- Reset values: all outputs 0; state=IDLE; vote counters 0; pair indices i=0, j=1.
- Pair order is lexicographic: (0,1),(0,2),…,(0,N-1),(1,2),…,(N-2,N-1).
  - pair_sel = p, the position of (i,j) in that order.
  - i and j are tracked by counters, with no lookup table.
- Vote rule: svm_class=0 votes for class i; svm_class=1 votes for class j.
- IDLE:
  - start=1 → SYNC. Votes, pair indices and watchdog clear to 0; timeout_err clears.
  - svm_ready is ignored in IDLE.
- SYNC:
  - The SVM is free-running and may be mid-round, so the first svm_ready is discarded.
  - pair_sel=0 during SYNC, so the next full round uses pair 0. Go to COLLECT.
- COLLECT, on each svm_ready:
  - Increment vote[i] or vote[j] per the vote rule.
  - Advance (i,j) and pair_sel in the same cycle, so the SVM round starting next cycle uses the new pair.
  - On the ready for p=N_PAIRS-1 → ARGMAX; pair_sel returns to 0.
- ARGMAX:
  - Scans classes 0..N_CLASSES-1, one per cycle, keeping best index and best count.
  - Replaces only on strictly greater count, so ties resolve to the lowest class index.
  - After the last class → DONE.
- DONE (one cycle): label ← best index; label_valid=1; busy deasserts; → IDLE.
- Latency, start to label_valid: at most (N_PAIRS+1)*(N_FEATURES+1) + N_CLASSES + 3 cycles.
- Watchdog:
  - In SYNC/COLLECT, a counter increments every cycle and clears on svm_ready.
  - Reaching N_FEATURES+2 with no ready sets timeout_err and sends the FSM to IDLE.
  - busy deasserts; label and label_valid are unchanged.
- start while busy is ignored; it causes no restart.
- Upstream must hold the feature vector stable from start until label_valid; the block does not latch features.
- Async reset mid-operation returns everything to reset values immediately; no label_valid is issued.

Test Plan:
- Bench config: N_CLASSES=3, N_FEATURES=4, SVM model with 5-cycle rounds; ready is arbitrarily phased after start.
- Pair results (0,1)→0, (0,2)→0, (1,2)→1 give votes {2,0,1} → label=0, one label_valid pulse; pair_sel sequence 0,1,2,0.
- Results 1,1,0 give votes {0,2,1} → label=1. Results 1,0,1 give votes {1,1,1} → tie, label=0.
- start asserted while busy in COLLECT → vote sequence and latency unchanged, exactly one label_valid.
- Hold svm_ready low after start → timeout_err=1 at watchdog count 6, busy=0, label unchanged; the next start clears timeout_err.
- Assert rst during ARGMAX → all outputs 0 next cycle, no label_valid. A fresh start then classifies correctly.

Source files
------------

// File: rtl/ovo_vote_collector.sv
// ovo_vote_collector
//   Drives a free-running sequential binary SVM through every one-vs-one class
//   pair, collects one vote per pair, then picks the class with the most votes.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   start        single-cycle classify request (accepted only when idle)
//   svm_ready    binary SVM round-complete strobe
//   svm_class    binary decision, valid with svm_ready (0 -> class i, 1 -> class j)
//   pair_sel     index of the active (i,j) pair, selects SVM weights/bias
//   busy         high while a classification is in progress
//   label        winning class, held until the next label_valid
//   label_valid  one-cycle pulse when label updates
//   timeout_err  sticky watchdog flag, cleared by the next accepted start
module ovo_vote_collector #(
  parameter int N_CLASSES   = 10,
  parameter int N_FEATURES  = 16,
  parameter int VOTE_WIDTH  = $clog2(N_CLASSES),
  parameter int LABEL_WIDTH = $clog2(N_CLASSES),
  parameter int PAIR_WIDTH  = $clog2(N_CLASSES * (N_CLASSES - 1) / 2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   svm_ready,
  input  logic                   svm_class,
  output logic [PAIR_WIDTH-1:0]  pair_sel,
  output logic                   busy,
  output logic [LABEL_WIDTH-1:0] label,
  output logic                   label_valid,
  output logic                   timeout_err
);

  localparam int N_PAIRS  = N_CLASSES * (N_CLASSES - 1) / 2;
  localparam int WD_LIMIT = N_FEATURES + 2;
  localparam int WD_WIDTH = $clog2(WD_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_COLLECT,
    S_ARGMAX,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [PAIR_WIDTH-1:0]  pair_q, pair_d;
  logic [LABEL_WIDTH-1:0] i_q, i_d;
  logic [LABEL_WIDTH-1:0] j_q, j_d;
  logic [VOTE_WIDTH-1:0]  votes_q [N_CLASSES];
  logic [VOTE_WIDTH-1:0]  votes_d [N_CLASSES];
  logic [WD_WIDTH-1:0]    wd_q, wd_d;
  logic [WD_WIDTH-1:0]    wd_inc;
  logic [LABEL_WIDTH-1:0] scan_q, scan_d;
  logic [LABEL_WIDTH-1:0] best_idx_q, best_idx_d;
  logic [VOTE_WIDTH-1:0]  best_cnt_q, best_cnt_d;
  logic [LABEL_WIDTH-1:0] label_q, label_d;
  logic                   timeout_q, timeout_d;

  always_comb begin
    state_d    = state_q;
    pair_d     = pair_q;
    i_d        = i_q;
    j_d        = j_q;
    votes_d    = votes_q;
    wd_d       = wd_q;
    scan_d     = scan_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    label_d    = label_q;
    timeout_d  = timeout_q;
    wd_inc     = wd_q + WD_WIDTH'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SYNC;
          pair_d    = '0;
          i_d       = '0;
          j_d       = LABEL_WIDTH'(1);
          wd_d      = '0;
          timeout_d = 1'b0;
          for (int c = 0; c < N_CLASSES; c++) begin
            votes_d[c] = '0;
          end
        end
      end

      // The SVM may be mid-round with stale weights; throw that result away.
      S_SYNC: begin
        if (svm_ready) begin
          wd_d    = '0;
          state_d = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (svm_ready) begin
          wd_d = '0;
          if (svm_class) begin
            votes_d[j_q] = votes_q[j_q] + VOTE_WIDTH'(1);
          end else begin
            votes_d[i_q] = votes_q[i_q] + VOTE_WIDTH'(1);
          end
          if (pair_q == PAIR_WIDTH'(N_PAIRS - 1)) begin
            state_d    = S_ARGMAX;
            pair_d     = '0;
            i_d        = '0;
            j_d        = LABEL_WIDTH'(1);
            scan_d     = '0;
            best_idx_d = '0;
            best_cnt_d = '0;
          end else begin
            // Switch weights now so the round that begins next cycle is clean.
            pair_d = pair_q + PAIR_WIDTH'(1);
            if (j_q == LABEL_WIDTH'(N_CLASSES - 1)) begin
              i_d = i_q + LABEL_WIDTH'(1);
              j_d = i_q + LABEL_WIDTH'(2);
            end else begin
              j_d = j_q + LABEL_WIDTH'(1);
            end
          end
        end
      end

      // Strict '>' keeps the earliest (lowest-index) class on ties.
      S_ARGMAX: begin
        if (votes_q[scan_q] > best_cnt_q) begin
          best_idx_d = scan_q;
          best_cnt_d = votes_q[scan_q];
        end
        if (scan_q == LABEL_WIDTH'(N_CLASSES - 1)) begin
          label_d = best_idx_d;
          state_d = S_DONE;
        end else begin
          scan_d = scan_q + LABEL_WIDTH'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Watchdog: a healthy SVM produces a ready every N_FEATURES+1 cycles.
    if ((state_q == S_SYNC || state_q == S_COLLECT) && !svm_ready) begin
      if (wd_inc == WD_WIDTH'(WD_LIMIT)) begin
        timeout_d = 1'b1;
        wd_d      = '0;
        state_d   = S_IDLE;
      end else begin
        wd_d = wd_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pair_q     <= '0;
      i_q        <= '0;
      j_q        <= LABEL_WIDTH'(1);
      wd_q       <= '0;
      scan_q     <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      label_q    <= '0;
      timeout_q  <= 1'b0;
      for (int c = 0; c < N_CLASSES; c++) begin
        votes_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pair_q     <= pair_d;
      i_q        <= i_d;
      j_q        <= j_d;
      wd_q       <= wd_d;
      scan_q     <= scan_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      label_q    <= label_d;
      timeout_q  <= timeout_d;
      for (int c = 0; c < N_CLASSES; c++) begin
        votes_q[c] <= votes_d[c];
      end
    end
  end

  assign pair_sel    = pair_q;
  assign busy        = (state_q == S_SYNC) || (state_q == S_COLLECT) || (state_q == S_ARGMAX);
  assign label       = label_q;
  assign label_valid = (state_q == S_DONE);
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_ovo_vote_collector.sv
module tb_ovo_vote_collector;

  localparam int NC = 3;
  localparam int NF = 4;
  localparam int NP = NC * (NC - 1) / 2;
  localparam int RL = NF + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       svm_ready;
  logic       svm_class;
  logic [1:0] pair_sel;
  logic       busy;
  logic [1:0] label;
  logic       label_valid;
  logic       timeout_err;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int phase  = 0;
  bit svm_en = 1'b1;
  bit res [NP];
  int lv_cnt = 0;
  int seq [$];

  ovo_vote_collector #(
    .N_CLASSES (NC),
    .N_FEATURES(NF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .svm_ready  (svm_ready),
    .svm_class  (svm_class),
    .pair_sel   (pair_sel),
    .busy       (busy),
    .label      (label),
    .label_valid(label_valid),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Free-running SVM: a round ends every RL cycles; decision from the result table
  // for the pair whose weights were selected during that round.
  initial begin
    svm_ready = 1'b0;
    svm_class = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      svm_ready = svm_en && ((cyc % RL) == phase);
      svm_class = svm_ready ? res[pair_sel] : 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (label_valid) lv_cnt++;
      if (busy && svm_ready) seq.push_back(int'(pair_sel));
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: one vote per lexicographic pair, then lowest-index argmax.
  function automatic int model_label();
    int v [NC];
    int p, best;
    p = 0;
    for (int c = 0; c < NC; c++) v[c] = 0;
    for (int a = 0; a < NC; a++)
      for (int b = a + 1; b < NC; b++) begin
        if (res[p]) v[b]++; else v[a]++;
        p++;
      end
    best = 0;
    for (int c = 1; c < NC; c++) if (v[c] > v[best]) best = c;
    return best;
  endfunction

  function automatic int first_ready_after(input int s);
    int r;
    r = s + 1;
    while ((r % RL) != phase) r++;
    return r;
  endfunction

  task automatic pulse_start(output int s);
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic set_res(input bit r0, input bit r1, input bit r2);
    res[0] = r0; res[1] = r1; res[2] = r2;
  endtask

  task automatic run_class(input bit busy_start);
    int s, r1, exp_cyc, lv0, k, exp_lbl;
    exp_lbl = model_label();
    lv0 = lv_cnt;
    seq.delete();
    pulse_start(s);
    check("busy_after_start", busy, 1);
    check("timeout_cleared", timeout_err, 0);
    r1 = first_ready_after(s);
    exp_cyc = r1 + RL * NP + NC + 1;
    if (busy_start) begin
      wait_until(r1 + RL + 2);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    k = 0;
    @(negedge clk);
    while (!label_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("label_valid_seen", label_valid, 1);
    check("latency_cycle", cyc, exp_cyc);
    check("label", label, exp_lbl);
    check("busy_at_valid", busy, 0);
    repeat (8) @(negedge clk);
    #1;
    check("label_valid_count", lv_cnt - lv0, 1);
    check("label_held", label, exp_lbl);
    check("pair_sel_idle", pair_sel, 0);
    check("seq_len", seq.size(), NP + 1);
    if (seq.size() == NP + 1) begin
      check("seq_sync", seq[0], 0);
      for (int q = 0; q < NP; q++) check("seq_pair", seq[q + 1], q);
    end
  endtask

  initial begin
    int s, lv0, prev_label, k, r1;
    rst   = 1'b1;
    start = 1'b0;
    set_res(0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_pair_sel", pair_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_label", label, 0);
    check("rst_label_valid", label_valid, 0);
    check("rst_timeout", timeout_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases: plain win, lowest-index tie, and start while busy.
    phase = 2; set_res(0, 0, 1); run_class(1'b0);
    phase = 0; set_res(1, 0, 1); run_class(1'b0);
    phase = 4; set_res(1, 1, 0); run_class(1'b1);

    // Watchdog: SVM silent after start.
    prev_label = int'(label);
    lv0 = lv_cnt;
    svm_en = 1'b0;
    pulse_start(s);
    k = 0;
    while (!timeout_err && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("timeout_set", timeout_err, 1);
    check("timeout_cycle", cyc, s + NF + 3);
    check("timeout_busy", busy, 0);
    check("timeout_label", label, prev_label);
    check("timeout_no_valid", lv_cnt - lv0, 0);
    svm_en = 1'b1;
    phase = 1; set_res(1, 1, 0); run_class(1'b0);

    // Reset in the middle of the argmax scan.
    phase = 3; set_res(0, 1, 1);
    lv0 = lv_cnt;
    pulse_start(s);
    r1 = first_ready_after(s);
    wait_until(r1 + RL * NP + 2);
    rst = 1'b1;
    @(negedge clk);
    check("argmax_rst_pair_sel", pair_sel, 0);
    check("argmax_rst_busy", busy, 0);
    check("argmax_rst_label", label, 0);
    check("argmax_rst_valid", label_valid, 0);
    check("argmax_rst_timeout", timeout_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("argmax_rst_no_valid", lv_cnt - lv0, 0);
    run_class(1'b0);

    // Randomized results and SVM phases.
    for (int t = 0; t < 8; t++) begin
      phase = int'($urandom_range(0, RL - 1));
      set_res(1'($urandom), 1'($urandom), 1'($urandom));
      run_class(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
